// File: rtl/npu_mmio_bridge.sv
// Host-side MMIO bridge in front of the NPU control unit: command registers, doorbell, status, MMVR readback.
// Build option: define MMIO_IRQ_EN to add a HALTED-edge interrupt (cleared by CTRL bit1).
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef ARG_WIDTH
`define ARG_WIDTH 32
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 256
`endif
`ifndef STATUS_IDLE
`define STATUS_IDLE 0
`endif
`ifndef STATUS_BUSY
`define STATUS_BUSY 1
`endif
`ifndef STATUS_HALTED
`define STATUS_HALTED 2
`endif
`ifndef CMD_WRITE_MEM
`define CMD_WRITE_MEM 1
`endif
`ifndef CMD_READ_MEM
`define CMD_READ_MEM 2
`endif
`ifndef CMD_RUN
`define CMD_RUN 3
`endif

module npu_mmio_bridge #(
  parameter int unsigned HOST_DW = `HOST_DATA_WIDTH,
  parameter int unsigned HOST_AW = 8,
  parameter int unsigned ADDR_W  = `ADDR_WIDTH,
  parameter int unsigned ARG_W   = `ARG_WIDTH,
  parameter int unsigned BUF_W   = `BUFFER_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_host_req,
  input  logic               i_host_we,
  input  logic [HOST_AW-1:0] i_host_addr,
  input  logic [HOST_DW-1:0] i_host_wdata,
  output logic               o_host_rvalid,
  output logic [HOST_DW-1:0] o_host_rdata,
  output logic [HOST_DW-1:0] o_cmd_out,
  output logic [ADDR_W-1:0]  o_addr_out,
  output logic [ARG_W-1:0]   o_arg_out,
  output logic [BUF_W-1:0]   o_mmvr_out,
  output logic               o_doorbell_pulse,
  input  logic [HOST_DW-1:0] i_status_in,
  input  logic [BUF_W-1:0]   i_mem_rdata_in,
  output logic               o_irq
);

  localparam int unsigned NW   = BUF_W / HOST_DW;
  localparam int unsigned IdxW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [HOST_DW-1:0] StIdle   = HOST_DW'(`STATUS_IDLE);
  localparam logic [HOST_DW-1:0] StBusy   = HOST_DW'(`STATUS_BUSY);
  localparam logic [HOST_DW-1:0] StHalted = HOST_DW'(`STATUS_HALTED);
  localparam logic [HOST_DW-1:0] CmdRead  = HOST_DW'(`CMD_READ_MEM);

  localparam logic [HOST_AW-1:0] OffCmd    = HOST_AW'(8'h00);
  localparam logic [HOST_AW-1:0] OffAddr   = HOST_AW'(8'h04);
  localparam logic [HOST_AW-1:0] OffArg    = HOST_AW'(8'h08);
  localparam logic [HOST_AW-1:0] OffDb     = HOST_AW'(8'h0C);
  localparam logic [HOST_AW-1:0] OffStatus = HOST_AW'(8'h10);
  localparam logic [HOST_AW-1:0] OffCtrl   = HOST_AW'(8'h14);
  localparam logic [HOST_AW-1:0] OffMmvr   = HOST_AW'(8'h20);
  localparam logic [HOST_AW-1:0] MmvrSpan  = HOST_AW'(4 * NW);

  localparam logic [1:0] TmoLast = 2'd3;

  typedef enum logic [1:0] {RbIdle, RbArmed, RbWait} rb_state_e;

  rb_state_e          r_rb_state, w_rb_state_d;
  logic [1:0]         r_tmo, w_tmo_d;
  logic [HOST_DW-1:0] r_cmd, w_cmd_d;
  logic [ADDR_W-1:0]  r_addr, w_addr_d;
  logic [ARG_W-1:0]   r_arg, w_arg_d;
  logic [BUF_W-1:0]   r_mmvr, w_mmvr_d;
  logic               r_doorbell;
  logic               r_err, w_err_d;
  logic               r_rvalid;
  logic [HOST_DW-1:0] r_rdata, w_rdata;

  logic               w_wr, w_rd, w_busy, w_rd_pend;
  logic               w_wr_cmd, w_wr_addr, w_wr_arg, w_wr_db, w_wr_ctrl, w_wr_mmvr;
  logic               w_db_halt_ok, w_db_accept, w_lock_err;
  logic               w_capture, w_tmo_err;
  logic [HOST_AW-1:0] w_mmvr_off;
  logic               w_mmvr_hit;
  logic [IdxW-1:0]    w_mmvr_idx;
  logic [HOST_DW-1:0] w_status_rd;

  assign w_wr       = i_host_req & i_host_we;
  assign w_rd       = i_host_req & ~i_host_we;
  assign w_rd_pend  = (r_rb_state != RbIdle);
  assign w_busy     = (i_status_in != StIdle) | r_doorbell | w_rd_pend;

  assign w_mmvr_off = i_host_addr - OffMmvr;
  assign w_mmvr_hit = (i_host_addr >= OffMmvr) && (w_mmvr_off < MmvrSpan) &&
                      (i_host_addr[1:0] == 2'b00);
  assign w_mmvr_idx = w_mmvr_off[IdxW+1:2];

  assign w_wr_cmd   = w_wr && (i_host_addr == OffCmd);
  assign w_wr_addr  = w_wr && (i_host_addr == OffAddr);
  assign w_wr_arg   = w_wr && (i_host_addr == OffArg);
  assign w_wr_db    = w_wr && (i_host_addr == OffDb);
  assign w_wr_ctrl  = w_wr && (i_host_addr == OffCtrl);
  assign w_wr_mmvr  = w_wr && w_mmvr_hit;

  // A doorbell is the only way out of HALTED, so it bypasses the status part of the lock.
  assign w_db_halt_ok = w_wr_db && (i_status_in == StHalted) && !r_doorbell && !w_rd_pend;
  assign w_db_accept  = w_wr_db && (!w_busy || w_db_halt_ok);
  assign w_lock_err   = (w_wr_cmd | w_wr_addr | w_wr_arg | w_wr_mmvr | w_wr_db) && w_busy &&
                        !w_db_halt_ok;

  always_comb begin
    w_rb_state_d = r_rb_state;
    w_tmo_d      = r_tmo;
    w_capture    = 1'b0;
    w_tmo_err    = 1'b0;
    case (r_rb_state)
      RbIdle: begin
        if (w_db_accept && (r_cmd == CmdRead)) begin
          w_rb_state_d = RbArmed;
          w_tmo_d      = '0;
        end
      end
      RbArmed: begin
        if (i_status_in == StBusy) begin
          w_rb_state_d = RbWait;
        end else if (r_tmo == TmoLast) begin
          w_tmo_err    = 1'b1;
          w_rb_state_d = RbIdle;
        end else begin
          w_tmo_d = r_tmo + 2'd1;
        end
      end
      RbWait: begin
        if (i_status_in == StIdle) begin
          w_capture    = 1'b1;
          w_rb_state_d = RbIdle;
        end
      end
      default: w_rb_state_d = RbIdle;
    endcase
  end

  always_comb begin
    w_cmd_d  = r_cmd;
    w_addr_d = r_addr;
    w_arg_d  = r_arg;
    w_mmvr_d = r_mmvr;
    if (w_wr_cmd && !w_busy) w_cmd_d = i_host_wdata;
    if (w_wr_addr && !w_busy) w_addr_d = ADDR_W'(i_host_wdata);
    if (w_wr_arg && !w_busy) w_arg_d = ARG_W'(i_host_wdata);
    if (w_capture) begin
      w_mmvr_d = i_mem_rdata_in;
    end else if (w_wr_mmvr && !w_busy) begin
      for (int i = 0; i < NW; i++) begin
        if (w_mmvr_idx == IdxW'(i)) w_mmvr_d[i*HOST_DW +: HOST_DW] = i_host_wdata;
      end
    end
    // Set beats a same-cycle W1C clear.
    w_err_d = w_lock_err | w_tmo_err | (r_err & ~(w_wr_ctrl & i_host_wdata[0]));
  end

`ifdef MMIO_IRQ_EN
  logic r_irq, r_halted_prev, w_irq_d;

  assign w_irq_d = ((i_status_in == StHalted) && !r_halted_prev) |
                   (r_irq & ~(w_wr_ctrl & i_host_wdata[1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq         <= 1'b0;
      r_halted_prev <= 1'b0;
    end else begin
      r_irq         <= w_irq_d;
      r_halted_prev <= (i_status_in == StHalted);
    end
  end

  assign o_irq       = r_irq;
  assign w_status_rd = {r_err, w_rd_pend, r_irq, i_status_in[HOST_DW-4:0]};
`else
  assign o_irq       = 1'b0;
  assign w_status_rd = {r_err, w_rd_pend, i_status_in[HOST_DW-3:0]};
`endif

  always_comb begin
    w_rdata = '0;
    if (w_mmvr_hit) begin
      w_rdata = r_mmvr[w_mmvr_idx*HOST_DW +: HOST_DW];
    end else begin
      case (i_host_addr)
        OffCmd:    w_rdata = r_cmd;
        OffAddr:   w_rdata = HOST_DW'(r_addr);
        OffArg:    w_rdata = HOST_DW'(r_arg);
        OffStatus: w_rdata = w_status_rd;
        default:   w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_state <= RbIdle;
      r_tmo      <= '0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_arg      <= '0;
      r_mmvr     <= '0;
      r_doorbell <= 1'b0;
      r_err      <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rb_state <= w_rb_state_d;
      r_tmo      <= w_tmo_d;
      r_cmd      <= w_cmd_d;
      r_addr     <= w_addr_d;
      r_arg      <= w_arg_d;
      r_mmvr     <= w_mmvr_d;
      r_doorbell <= w_db_accept;
      r_err      <= w_err_d;
      r_rvalid   <= w_rd;
      r_rdata    <= w_rd ? w_rdata : '0;
    end
  end

  assign o_host_rvalid    = r_rvalid;
  assign o_host_rdata     = r_rdata;
  assign o_cmd_out        = r_cmd;
  assign o_addr_out       = r_addr;
  assign o_arg_out        = r_arg;
  assign o_mmvr_out       = r_mmvr;
  assign o_doorbell_pulse = r_doorbell;

endmodule
